// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch (read-only) and the
// data side (read/write). One access in flight; data wins unless fetch has starved.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [2:0]    LAT_INIT   = 3'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state;
  logic [2:0]          lat_cnt;
  logic [SW-1:0]       streak;
  logic                wr_q;
  logic [DATA_W-1:0]   inst_hold, data_hold;
  logic                grant_d, grant_i, last;

  // No grant while reset is held, so every output reads 0 during reset.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE && rst) begin
      if (data_req && !(inst_req && streak == STREAK_MAX)) grant_d = 1'b1;
      else if (inst_req)                                   grant_i = 1'b1;
    end
  end

  always_comb begin
    mem_en    = grant_d | grant_i;
    mem_wen   = grant_d ? data_wen   : '0;
    mem_wdata = grant_d ? data_wdata : '0;
    mem_addr  = grant_d ? data_addr : (grant_i ? inst_addr : '0);
  end

  assign last       = (state != IDLE) && (lat_cnt == 3'd1);
  assign inst_done  = last && (state == BUSY_I);
  assign data_done  = last && (state == BUSY_D);
  assign inst_rdata = inst_done ? mem_rdata : inst_hold;
  assign data_rdata = (data_done && !wr_q) ? mem_rdata : data_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      streak    <= '0;
      wr_q      <= 1'b0;
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= BUSY_D;
            lat_cnt <= LAT_INIT;
            wr_q    <= |data_wen;
            if (!inst_req)                streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
          end else if (grant_i) begin
            state   <= BUSY_I;
            lat_cnt <= LAT_INIT;
            wr_q    <= 1'b0;
            streak  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            if (state == BUSY_I) inst_hold <= mem_rdata;
            else if (!wr_q)      data_hold <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: vector table on a latency-1 instance, hand sequences on a
// latency-3 instance for multi-cycle timing, drop-out and mid-access reset.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // latency-1 instance
  logic        inst_req = 0, data_req = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic [3:0]  data_wen = 0;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        inst_done, data_done, mem_en;
  logic [3:0]  mem_wen;

  sram_port_arbiter #(.READ_LATENCY(1), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  // latency-3 instance
  logic        inst_req3 = 0, data_req3 = 0;
  logic [31:0] inst_addr3 = 0, data_addr3 = 0, data_wdata3 = 0, mem_rdata3 = 0;
  logic [3:0]  data_wen3 = 0;
  logic [31:0] inst_rdata3, data_rdata3, mem_addr3, mem_wdata3;
  logic        inst_done3, data_done3, mem_en3;
  logic [3:0]  mem_wen3;

  sram_port_arbiter #(.READ_LATENCY(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req3), .inst_addr(inst_addr3), .inst_rdata(inst_rdata3), .inst_done(inst_done3),
    .data_req(data_req3), .data_wen(data_wen3), .data_addr(data_addr3), .data_wdata(data_wdata3),
    .data_rdata(data_rdata3), .data_done(data_done3),
    .mem_en(mem_en3), .mem_wen(mem_wen3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic ireq; logic [31:0] iaddr;
    logic dreq; logic [3:0] dwen; logic [31:0] daddr; logic [31:0] dwdata; logic [31:0] mrd;
    logic men; logic [3:0] mwen; logic [31:0] maddr; logic [31:0] mwdata;
    logic idone; logic [31:0] irdata; logic ddone; logic [31:0] drdata;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];
  string gseq;
  logic [31:0] prev_en;

  initial begin
    //             rst ireq iaddr   dreq dwen     daddr    dwdata   mrd            | men mwen     maddr    mwdata  idone irdata         ddone drdata
    vt[0]  = '{1'b0,1'b1,32'h100,1'b1,4'h0,    32'h9,   32'h0,   32'h0,         1'b0,4'h0,    32'h0,   32'h0,   1'b0,32'h0,        1'b0,32'h0};
    vt[1]  = '{1'b1,1'b1,32'h100,1'b0,4'h0,    32'h0,   32'h0,   32'h0,         1'b1,4'h0,    32'h100, 32'h0,   1'b0,32'h0,        1'b0,32'h0};
    vt[2]  = '{1'b1,1'b1,32'h100,1'b0,4'h0,    32'h0,   32'h0,   32'hDEADBEEF,  1'b0,4'h0,    32'h0,   32'h0,   1'b1,32'hDEADBEEF, 1'b0,32'h0};
    vt[3]  = '{1'b1,1'b0,32'h0,  1'b0,4'h0,    32'h0,   32'h0,   32'h55,        1'b0,4'h0,    32'h0,   32'h0,   1'b0,32'hDEADBEEF, 1'b0,32'h0};
    vt[4]  = '{1'b1,1'b0,32'h0,  1'b1,4'b0011, 32'h2002,32'h1234,32'h0,         1'b1,4'b0011, 32'h2002,32'h1234,1'b0,32'hDEADBEEF, 1'b0,32'h0};
    vt[5]  = '{1'b1,1'b0,32'h0,  1'b1,4'b0011, 32'h2002,32'h1234,32'hCAFE0000,  1'b0,4'h0,    32'h0,   32'h0,   1'b0,32'hDEADBEEF, 1'b1,32'h0};
    vt[6]  = '{1'b1,1'b0,32'h0,  1'b0,4'h0,    32'h0,   32'h0,   32'h0,         1'b0,4'h0,    32'h0,   32'h0,   1'b0,32'hDEADBEEF, 1'b0,32'h0};
    vt[7]  = '{1'b1,1'b0,32'h0,  1'b1,4'h0,    32'h3000,32'h0,   32'h0,         1'b1,4'h0,    32'h3000,32'h0,   1'b0,32'hDEADBEEF, 1'b0,32'h0};
    vt[8]  = '{1'b1,1'b1,32'h104,1'b1,4'h0,    32'h3000,32'h0,   32'h11223344,  1'b0,4'h0,    32'h0,   32'h0,   1'b0,32'hDEADBEEF, 1'b1,32'h11223344};
    vt[9]  = '{1'b1,1'b1,32'h104,1'b0,4'h0,    32'h0,   32'h0,   32'h0,         1'b1,4'h0,    32'h104, 32'h0,   1'b0,32'hDEADBEEF, 1'b0,32'h11223344};
    vt[10] = '{1'b1,1'b0,32'h0,  1'b0,4'h0,    32'h0,   32'h0,   32'h99,        1'b0,4'h0,    32'h0,   32'h0,   1'b1,32'h99,       1'b0,32'h11223344};

    repeat (2) @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vt[i].rst; inst_req = vt[i].ireq; inst_addr = vt[i].iaddr;
      data_req = vt[i].dreq; data_wen = vt[i].dwen; data_addr = vt[i].daddr;
      data_wdata = vt[i].dwdata; mem_rdata = vt[i].mrd;
      #1;
      chk($sformatf("v%0d mem_en", i),     {31'h0, mem_en},    {31'h0, vt[i].men});
      chk($sformatf("v%0d mem_wen", i),    {28'h0, mem_wen},   {28'h0, vt[i].mwen});
      chk($sformatf("v%0d mem_addr", i),   mem_addr,           vt[i].maddr);
      chk($sformatf("v%0d mem_wdata", i),  mem_wdata,          vt[i].mwdata);
      chk($sformatf("v%0d inst_done", i),  {31'h0, inst_done}, {31'h0, vt[i].idone});
      chk($sformatf("v%0d inst_rdata", i), inst_rdata,         vt[i].irdata);
      chk($sformatf("v%0d data_done", i),  {31'h0, data_done}, {31'h0, vt[i].ddone});
      chk($sformatf("v%0d data_rdata", i), data_rdata,         vt[i].drdata);
    end

    // Both requesters held: streak limit lets fetch in after four data grants.
    gseq = "";
    prev_en = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h400; data_req = 1; data_wen = 0;
      data_addr = 32'h800; data_wdata = 0; mem_rdata = 0;
      #1;
      if (mem_en) gseq = {gseq, (mem_addr == 32'h800) ? "D" : "I"};
      chk($sformatf("b2b c%0d", c), {31'h0, mem_en & prev_en[0]}, 32'h0);
      prev_en = {31'h0, mem_en};
    end
    checks++;
    if (gseq != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL grant_order: got %s expected DDDDIDDDDI", gseq);
    end
    @(negedge clk);
    inst_req = 0; data_req = 0;
    repeat (2) @(negedge clk);

    // Latency-3 load: done exactly at T+3, next issue at T+4.
    data_req3 = 1; data_addr3 = 32'h40; #1;
    chk("l3 issue", {31'h0, mem_en3}, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      mem_rdata3 = (k == 3) ? 32'hA5A50003 : 32'h0;
      #1;
      chk($sformatf("l3 done T+%0d", k), {31'h0, data_done3}, {31'h0, k == 3});
      chk($sformatf("l3 en T+%0d", k),   {31'h0, mem_en3}, 32'h0);
    end
    chk("l3 rdata", data_rdata3, 32'hA5A50003);
    @(negedge clk); mem_rdata3 = 0; #1;
    chk("l3 reissue T+4", {31'h0, mem_en3}, 32'h1);
    chk("l3 reissue addr", mem_addr3, 32'h40);

    // Requester drops one cycle in: access still completes, no re-issue.
    @(negedge clk); data_req3 = 0; #1;
    chk("drop done T+1", {31'h0, data_done3}, 32'h0);
    @(negedge clk); #1;
    chk("drop done T+2", {31'h0, data_done3}, 32'h0);
    @(negedge clk); mem_rdata3 = 32'h77; #1;
    chk("drop done T+3", {31'h0, data_done3}, 32'h1);
    chk("drop rdata", data_rdata3, 32'h77);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_rdata3 = 0; #1;
      chk($sformatf("drop idle en %0d", k), {31'h0, mem_en3}, 32'h0);
      chk($sformatf("drop idle done %0d", k), {31'h0, data_done3}, 32'h0);
    end

    // Reset in the middle of a data access.
    @(negedge clk); data_req3 = 1; data_addr3 = 32'h80; #1;
    chk("rst pre issue", {31'h0, mem_en3}, 32'h1);
    @(negedge clk); rst = 0; #1;
    chk("rst mem_en", {31'h0, mem_en3}, 32'h0);
    chk("rst data_done", {31'h0, data_done3}, 32'h0);
    chk("rst data_rdata", data_rdata3, 32'h0);
    chk("rst l1 inst_rdata", inst_rdata, 32'h0);
    chk("rst l1 data_rdata", data_rdata, 32'h0);
    @(negedge clk); #1;
    chk("rst held mem_en", {31'h0, mem_en3}, 32'h0);
    @(negedge clk); rst = 1; data_req3 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_rdata3 = 32'hFF; #1;
      chk($sformatf("post rst done %0d", k), {31'h0, data_done3}, 32'h0);
      chk($sformatf("post rst rdata %0d", k), data_rdata3, 32'h0);
    end
    @(negedge clk); data_req3 = 1; data_addr3 = 32'hC0; #1;
    chk("post rst idle issue", {31'h0, mem_en3}, 32'h1);
    chk("post rst idle addr", mem_addr3, 32'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
